// File: rtl/la_cap_pkg.sv
// la_cap_pkg
// Shared types and constants for the logic-analyzer capture controller.
//   - la_state_e : capture sequencer states (IDLE, ARMED, POST, DONE)
//   - LA_DATA_W / LA_DEPTH_LOG2 : default probe width and buffer depth (log2)
//   - fill_w()   : width of the fill counter, wide enough to hold DEPTH itself
package la_cap_pkg;

  localparam int LA_DATA_W     = 8;
  localparam int LA_DEPTH_LOG2 = 6;

  typedef enum logic [1:0] {
    LA_IDLE  = 2'd0,
    LA_ARMED = 2'd1,
    LA_POST  = 2'd2,
    LA_DONE  = 2'd3
  } la_state_e;

  // The fill counter must represent 0..DEPTH inclusive, so one bit more
  // than the buffer address.
  function automatic int fill_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/la_cap_ram.sv
// la_cap_ram
// Simple dual-port synchronous RAM for the capture buffer: one write port,
// one read port with a registered output (1-cycle latency). Contents are
// not reset so the array maps onto block RAM.
// Ports:
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata updates only when re is high
//   raddr  : read address
//   rdata  : registered read data
module la_cap_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl
// Logic-analyzer capture sequencer. Samples data_i into a circular buffer
// while armed, fires on a masked compare, stores post_cnt_i further samples
// and then freezes the buffer for indexed, oldest-first readout.
// Optional build macro: LA_EDGE_TRIG_EN -- trigger only on a rising edge of
// the compare match (previous sample did not match).
// Ports:
//   sys_clk, sys_rst      : clock, asynchronous active-high reset
//   data_i                : probe bus
//   arm_i, abort_i        : start capture / cancel (abort wins)
//   trig_mask_i/value_i   : masked compare trigger (mask bit 1 = compared)
//   post_cnt_i            : samples stored after the trigger sample
//   busy_o, triggered_o,
//   done_o                : status
//   valid_cnt_o, trig_pos_o : capture geometry, non-zero only while done_o
//   rd_en_i, rd_idx_i     : read request, index 0 = oldest sample
//   rd_data_o, rd_valid_o : read data, valid pulse one cycle after rd_en_i
module la_capture_ctrl
  import la_cap_pkg::*;
#(
  parameter int DATA_W     = LA_DATA_W,
  parameter int DEPTH_LOG2 = LA_DEPTH_LOG2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic [DATA_W-1:0]     trig_mask_i,
  input  logic [DATA_W-1:0]     trig_value_i,
  input  logic [DEPTH_LOG2-1:0] post_cnt_i,
  output logic                  busy_o,
  output logic                  triggered_o,
  output logic                  done_o,
  output logic [DEPTH_LOG2:0]   valid_cnt_o,
  output logic [DEPTH_LOG2-1:0] trig_pos_o,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_idx_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  rd_valid_o
);

  localparam int FW = fill_w(DEPTH_LOG2);
  localparam logic [FW-1:0] DEPTH_FILL = FW'(1 << DEPTH_LOG2);

  localparam logic [1:0] ST_IDLE  = LA_IDLE;
  localparam logic [1:0] ST_ARMED = LA_ARMED;
  localparam logic [1:0] ST_POST  = LA_POST;
  localparam logic [1:0] ST_DONE  = LA_DONE;

  logic [1:0]            state_reg,     state_next;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg,    wr_ptr_next;
  logic [FW-1:0]         fill_reg,      fill_next;
  logic [DEPTH_LOG2-1:0] remaining_reg, remaining_next;
  logic [DEPTH_LOG2-1:0] trig_addr_reg, trig_addr_next;
  logic                  triggered_reg, triggered_next;
  logic                  busy_reg,      busy_next;
  logic                  done_reg,      done_next;
  logic [FW-1:0]         valid_cnt_reg, valid_cnt_next;
  logic [DEPTH_LOG2-1:0] trig_pos_reg,  trig_pos_next;
  logic                  rd_valid_reg;
  logic                  rd_zero_reg;

  logic                  match;
  logic                  trig_hit;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] oldest;
  logic [DEPTH_LOG2-1:0] oldest_next;
  logic [DEPTH_LOG2-1:0] ram_raddr;
  logic [DATA_W-1:0]     ram_q;

  assign match = ((data_i ^ trig_value_i) & trig_mask_i) == '0;

`ifdef LA_EDGE_TRIG_EN
  logic prev_match_reg, prev_match_next;
  assign trig_hit = match & ~prev_match_reg;
`else
  assign trig_hit = match;
`endif

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    fill_next      = fill_reg;
    remaining_next = remaining_reg;
    trig_addr_next = trig_addr_reg;
    triggered_next = triggered_reg;
    ram_we         = 1'b0;
`ifdef LA_EDGE_TRIG_EN
    prev_match_next = prev_match_reg;
`endif

    case (state_reg)
      ST_ARMED, ST_POST: begin
        ram_we      = 1'b1;
        wr_ptr_next = wr_ptr_reg + 1'b1;
        if (fill_reg != DEPTH_FILL) begin
          fill_next = fill_reg + 1'b1;
        end
        if (state_reg == ST_ARMED) begin
`ifdef LA_EDGE_TRIG_EN
          prev_match_next = match;
`endif
          if (trig_hit) begin
            trig_addr_next = wr_ptr_reg;
            triggered_next = 1'b1;
            state_next     = (remaining_reg == '0) ? ST_DONE : ST_POST;
          end
        end else begin
          // POST is only entered with remaining >= 1, so this write at
          // remaining == 1 is the final one.
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == DEPTH_LOG2'(1)) begin
            state_next = ST_DONE;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a (re-)arm; ARMED/POST ignore it.
        if (arm_i) begin
          state_next     = ST_ARMED;
          wr_ptr_next    = '0;
          fill_next      = '0;
          triggered_next = 1'b0;
          remaining_next = post_cnt_i;
`ifdef LA_EDGE_TRIG_EN
          // Pretend the sample before arming matched so a level that is
          // already true cannot fire on the first ARMED sample.
          prev_match_next = 1'b1;
`endif
        end
      end
    endcase

    if (abort_i) begin
      state_next     = ST_IDLE;
      triggered_next = 1'b0;
    end
  end

  // Status outputs are registered from next-state values so they line up
  // with the state they describe.
  assign oldest_next    = wr_ptr_next - fill_next[DEPTH_LOG2-1:0];
  assign busy_next      = (state_next == ST_ARMED) || (state_next == ST_POST);
  assign done_next      = (state_next == ST_DONE);
  assign valid_cnt_next = done_next ? fill_next : '0;
  assign trig_pos_next  = done_next ? (trig_addr_next - oldest_next) : '0;

  // With fill == DEPTH the low bits are zero and oldest == wr_ptr, which is
  // exactly the slot about to be overwritten: the wrap case falls out free.
  assign oldest    = wr_ptr_reg - fill_reg[DEPTH_LOG2-1:0];
  assign ram_raddr = oldest + rd_idx_i;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      fill_reg       <= '0;
      remaining_reg  <= '0;
      trig_addr_reg  <= '0;
      triggered_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      valid_cnt_reg  <= '0;
      trig_pos_reg   <= '0;
      rd_valid_reg   <= 1'b0;
      rd_zero_reg    <= 1'b1;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      fill_reg       <= fill_next;
      remaining_reg  <= remaining_next;
      trig_addr_reg  <= trig_addr_next;
      triggered_reg  <= triggered_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      valid_cnt_reg  <= valid_cnt_next;
      trig_pos_reg   <= trig_pos_next;
      rd_valid_reg   <= rd_en_i;
      // Out-of-range or not-frozen reads return zero; the flag only moves
      // with a read so rd_data_o holds between reads.
      if (rd_en_i) begin
        rd_zero_reg <= (state_reg != ST_DONE) ||
                       ({1'b0, rd_idx_i} >= valid_cnt_reg);
      end
    end
  end

`ifdef LA_EDGE_TRIG_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      prev_match_reg <= 1'b1;
    end else begin
      prev_match_reg <= prev_match_next;
    end
  end
`endif

  la_cap_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (sys_clk),
    .we    (ram_we),
    .waddr (wr_ptr_reg),
    .wdata (data_i),
    .re    (rd_en_i),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  assign busy_o      = busy_reg;
  assign triggered_o = triggered_reg;
  assign done_o      = done_reg;
  assign valid_cnt_o = valid_cnt_reg;
  assign trig_pos_o  = trig_pos_reg;
  assign rd_valid_o  = rd_valid_reg;
  assign rd_data_o   = rd_zero_reg ? '0 : ram_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// tb_la_capture_ctrl
// Self-checking bench for la_capture_ctrl. A behavioural model works on the
// list of samples presented after arming: find the first trigger sample,
// add the post count, keep the last DEPTH samples, and derive counts,
// trigger position and read data from that window.
module tb_la_capture_ctrl;

  localparam int DW    = 8;
  localparam int DL    = 6;
  localparam int DEPTH = 64;
  localparam int NSTIM = 512;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic          arm_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [DW-1:0] trig_mask_i = '0;
  logic [DW-1:0] trig_value_i = '0;
  logic [DL-1:0] post_cnt_i = '0;
  logic          busy_o;
  logic          triggered_o;
  logic          done_o;
  logic [DL:0]   valid_cnt_o;
  logic [DL-1:0] trig_pos_o;
  logic          rd_en_i = 1'b0;
  logic [DL-1:0] rd_idx_i = '0;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] stim [0:NSTIM-1];

  // Results of the most recent modelled capture.
  bit m_hit;
  int m_total;
  int m_trig;
  int m_base;
  int m_cnt;

  always #5 sys_clk = ~sys_clk;

  la_capture_ctrl dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .data_i       (data_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
    .post_cnt_i   (post_cnt_i),
    .busy_o       (busy_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o),
    .valid_cnt_o  (valid_cnt_o),
    .trig_pos_o   (trig_pos_o),
    .rd_en_i      (rd_en_i),
    .rd_idx_i     (rd_idx_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Model: first trigger sample, total samples written, surviving window.
  task automatic model_capture(input logic [DW-1:0] mask, input logic [DW-1:0] value, input int post);
    bit prev_m;
    bit m;
    bit fire;
    m_hit  = 1'b0;
    prev_m = 1'b1;
    for (int k = 0; k + 1 + post <= NSTIM; k++) begin
      m = (((stim[k] ^ value) & mask) == 0);
`ifdef LA_EDGE_TRIG_EN
      fire = m && !prev_m;
`else
      fire = m;
`endif
      prev_m = m;
      if (fire) begin
        m_hit = 1'b1;
        m_trig = k;
        break;
      end
    end
    if (m_hit) begin
      m_total = m_trig + 1 + post;
      m_cnt   = (m_total < DEPTH) ? m_total : DEPTH;
      m_base  = m_total - m_cnt;
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int idx);
    if (!m_hit || idx >= m_cnt) return '0;
    return stim[m_base + idx];
  endfunction

  task automatic do_read(input int idx, input logic [DW-1:0] exp, input string tag);
    rd_en_i  = 1'b1;
    rd_idx_i = DL'(idx);
    tick();
    rd_en_i = 1'b0;
    check_val({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
    check_val({tag, "_data"}, 32'(rd_data_o), 32'(exp));
    tick();
    check_val({tag, "_vdrop"}, 32'(rd_valid_o), 32'd0);
    check_val({tag, "_hold"}, 32'(rd_data_o), 32'(exp));
  endtask

  // Arm, feed stim[] one sample per cycle, check against the model.
  task automatic run_capture(input logic [DW-1:0] mask, input logic [DW-1:0] value,
                             input int post, input string tag);
    int k;
    int limit;
    model_capture(mask, value, post);
    trig_mask_i  = mask;
    trig_value_i = value;
    post_cnt_i   = DL'(post);
    data_i       = stim[0];
    arm_i        = 1'b1;
    tick();
    arm_i = 1'b0;
    check_val({tag, "_busy_arm"}, 32'(busy_o), 32'd1);
    check_val({tag, "_done_arm"}, 32'(done_o), 32'd0);
    limit = m_hit ? m_total + 2 : NSTIM;
    k = 0;
    while (k < limit && k < NSTIM) begin
      data_i = stim[k];
      tick();
      k++;
      if (done_o) break;
    end
    $display("capture %s mask=%02h value=%02h post=%0d hit=%0d samples=%0d",
             tag, mask, value, post, m_hit, k);
    if (m_hit) begin
      check_val({tag, "_done"}, 32'(done_o), 32'd1);
      check_val({tag, "_latency"}, 32'(k), 32'(m_total));
      check_val({tag, "_busy_done"}, 32'(busy_o), 32'd0);
      check_val({tag, "_triggered"}, 32'(triggered_o), 32'd1);
      check_val({tag, "_valid_cnt"}, 32'(valid_cnt_o), 32'(m_cnt));
      check_val({tag, "_trig_pos"}, 32'(trig_pos_o), 32'(m_trig - m_base));
      do_read(0, model_read(0), {tag, "_rd_first"});
      do_read(m_trig - m_base, model_read(m_trig - m_base), {tag, "_rd_trig"});
      do_read(m_cnt - 1, model_read(m_cnt - 1), {tag, "_rd_last"});
      if (m_cnt < DEPTH) do_read(m_cnt, 8'h00, {tag, "_rd_oob"});
    end else begin
      check_val({tag, "_no_done"}, 32'(done_o), 32'd0);
      check_val({tag, "_still_busy"}, 32'(busy_o), 32'd1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check_val({tag, "_abort_busy"}, 32'(busy_o), 32'd0);
    end
  endtask

  task automatic fill_counter();
    for (int i = 0; i < NSTIM; i++) stim[i] = DW'(i);
  endtask

  initial begin
    // Reset state.
    #2;
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_done", 32'(done_o), 32'd0);
    check_val("rst_trig", 32'(triggered_o), 32'd0);
    check_val("rst_valid_cnt", 32'(valid_cnt_o), 32'd0);
    check_val("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    check_val("rst_rd_data", 32'(rd_data_o), 32'd0);
    tick();
    tick();
    sys_rst = 1'b0;
    tick();

    // Level trigger on a counter.
    fill_counter();
    run_capture(8'hFF, 8'h20, 8, "level");
`ifndef LA_EDGE_TRIG_EN
    check_val("level_const_cnt", 32'(valid_cnt_o), 32'd41);
    check_val("level_const_pos", 32'(trig_pos_o), 32'd32);
    do_read(0, 8'h00, "level_idx0");
    do_read(32, 8'h20, "level_idx32");
    do_read(40, 8'h28, "level_idx40");
`endif

    // Re-arm from DONE clears done and the count.
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    check_val("rearm_done", 32'(done_o), 32'd0);
    check_val("rearm_valid_cnt", 32'(valid_cnt_o), 32'd0);
    check_val("rearm_busy", 32'(busy_o), 32'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    // Buffer wrap.
    run_capture(8'hFF, 8'h50, 10, "wrap");
`ifndef LA_EDGE_TRIG_EN
    check_val("wrap_const_cnt", 32'(valid_cnt_o), 32'd64);
    check_val("wrap_const_pos", 32'(trig_pos_o), 32'd53);
    do_read(0, 8'h1B, "wrap_idx0");
    do_read(63, 8'h5A, "wrap_idx63");
`endif

    // Mask 0, post 0.
    run_capture(8'h00, 8'h00, 0, "immediate");
`ifndef LA_EDGE_TRIG_EN
    check_val("imm_const_cnt", 32'(valid_cnt_o), 32'd1);
    do_read(1, 8'h00, "imm_idx1");
`endif

    // Abort in POST.
    trig_mask_i  = 8'hFF;
    trig_value_i = 8'h05;
    post_cnt_i   = DL'(8);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      data_i = stim[k];
      tick();
    end
    check_val("abort_pre_trig", 32'(triggered_o), 32'd1);
    check_val("abort_pre_busy", 32'(busy_o), 32'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_val("abort_busy", 32'(busy_o), 32'd0);
    check_val("abort_done", 32'(done_o), 32'd0);
    check_val("abort_trig", 32'(triggered_o), 32'd0);
    $display("abort in POST");

    // Arm and abort together from IDLE: stays idle.
    arm_i   = 1'b1;
    abort_i = 1'b1;
    tick();
    arm_i   = 1'b0;
    abort_i = 1'b0;
    check_val("armabort_busy", 32'(busy_o), 32'd0);
    tick();
    check_val("armabort_busy2", 32'(busy_o), 32'd0);
    do_read(0, 8'h00, "idle_read");

    // Asynchronous reset mid-POST, then a clean recapture.
    trig_mask_i  = 8'hFF;
    trig_value_i = 8'h03;
    post_cnt_i   = DL'(20);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      data_i = stim[k];
      tick();
    end
    check_val("midpost_trig", 32'(triggered_o), 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    check_val("arst_busy", 32'(busy_o), 32'd0);
    check_val("arst_trig", 32'(triggered_o), 32'd0);
    check_val("arst_done", 32'(done_o), 32'd0);
    tick();
    sys_rst = 1'b0;
    $display("reset mid-POST");
    run_capture(8'hFF, 8'h20, 8, "after_rst");

    // Edge-trigger pattern: 0x20 through arm, 0x21, 0x20.
    stim[0] = 8'h20;
    stim[1] = 8'h21;
    for (int i = 2; i < NSTIM; i++) stim[i] = 8'h20;
    run_capture(8'hFF, 8'h20, 0, "edge");
`ifdef LA_EDGE_TRIG_EN
    check_val("edge_const_pos", 32'(trig_pos_o), 32'd2);
`endif

    // Randomized captures.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NSTIM; i++) stim[i] = DW'($urandom);
      run_capture(DW'($urandom) & 8'h0F, DW'($urandom), int'($urandom_range(0, DEPTH - 1)),
                  $sformatf("rand%0d", r));
      if (done_o) begin
        for (int j = 0; j < 4; j++) begin
          int idx;
          idx = int'($urandom_range(0, DEPTH - 1));
          do_read(idx, model_read(idx), $sformatf("rand%0d_rd%0d", r, j));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
- In-fabric logic-analyzer capture sequencer for the LED counter datapath: samples an 8-bit probe bus every sys_clk into a circular buffer.
- Evaluates a masked-compare trigger, collects a programmable number of post-trigger samples, then freezes the buffer.
- Presents captured data over an indexed read handshake ordered oldest-first.
- Sits beside the counter logic as a lightweight alternative to the JTAG analyzer core; the read port is driven by a host or UART bridge.

Parameters:
DATA_W, 8, probe/sample width
DEPTH_LOG2, 6, log2 of buffer depth (DEPTH = 64)

Ports:
sys_clk  in  1  capture/system clock
sys_rst  in  1  asynchronous reset, active-high
data_i  in  DATA_W  probe bus (counter value)
arm_i  in  1  start-capture pulse
abort_i  in  1  cancel pulse, any state
trig_mask_i  in  DATA_W  compare mask (1 = bit compared)
trig_value_i  in  DATA_W  compare value
post_cnt_i  in  DEPTH_LOG2  samples stored after the trigger sample; sampled on arm
busy_o  out  1  high in ARMED or POST
triggered_o  out  1  high from the trigger sample until the next arm or abort
done_o  out  1  high in DONE
valid_cnt_o  out  DEPTH_LOG2+1  valid samples in buffer, 0..DEPTH
trig_pos_o  out  DEPTH_LOG2  readout index of the trigger sample
rd_en_i  in  1  read request
rd_idx_i  in  DEPTH_LOG2  readout index, 0 = oldest
rd_data_o  out  DATA_W  read data
rd_valid_o  out  1  one-cycle pulse, one cycle after rd_en_i

Behaviour:
- Reset: state IDLE; all outputs 0; wr_ptr = 0, fill = 0. Buffer RAM contents are not reset.
- States: IDLE, ARMED, POST, DONE.
- IDLE: no writes. arm_i -> ARMED; clear wr_ptr, fill, triggered; latch post_cnt_i into remaining.
- ARMED: each cycle write data_i at wr_ptr. wr_ptr increments mod DEPTH; fill increments, saturating at DEPTH.
- Trigger: match = ((data_i ^ trig_value_i) & trig_mask_i) == 0, evaluated on the sample written in that cycle.
  - On match: trig_addr = wr_ptr; triggered_o = 1 from the next cycle.
  - remaining == 0 -> DONE; otherwise -> POST.
  - Mask 0 triggers on the first ARMED sample.
- POST: write each cycle and decrement remaining. The write made with remaining == 1 is the last one; next state DONE.
- Post-trigger depth: post_cnt_i is at most DEPTH-1 by width, so the trigger sample is never overwritten.
- DONE: writes stop.
  - valid_cnt_o = fill.
  - oldest = (wr_ptr - fill) mod DEPTH.
  - trig_pos_o = (trig_addr - oldest) mod DEPTH.
  - arm_i re-arms, with the same action as from IDLE.
- arm_i in ARMED or POST is ignored.
- abort_i in any state -> IDLE next cycle; clears done, busy and triggered. abort_i wins over a simultaneous arm_i.
- Read port:
  - rd_en_i at cycle N -> rd_valid_o = 1 at N+1, with rd_data_o = RAM[(oldest + rd_idx_i) mod DEPTH].
  - rd_data_o = 0 in either of these cases: rd_idx_i >= valid_cnt_o, or state is not DONE.
  - rd_data_o holds its value between reads.
  - Back-to-back reads are permitted, one per cycle.
- Status outputs and valid_cnt_o are registered. valid_cnt_o and trig_pos_o are meaningful only while done_o = 1 and read 0 otherwise.

Optional Feature:
LA_EDGE_TRIG_EN
- Defined: the trigger requires match on the current sample AND no match on the previous sample (prev_match register). prev_match is set to 1 on arm, so the first ARMED sample can never trigger.
- Undefined: level trigger exactly as above, and no prev_match register.

Decomposition:
- Package la_cap_pkg holds:
  - state enum (IDLE, ARMED, POST, DONE);
  - default DATA_W and DEPTH_LOG2 constants;
  - width helper for the fill counter (DEPTH_LOG2+1).
- Sub-module la_cap_ram: simple dual-port synchronous RAM, DEPTH x DATA_W, with one write port and a registered read port (1-cycle latency), inferable as Gowin block RAM. The controller owns pointers, FSM and output muxing.

Test Plan:
- Level trigger: data_i counts 0x00 upward one per cycle starting at the first ARMED cycle; mask 0xFF, value 0x20, post 8 -> done_o asserted; valid_cnt 41, trig_pos 32; read idx 0 -> 0x00, idx 32 -> 0x20, idx 40 -> 0x28.
- Wrap: same counter, value 0x50, post 10 -> valid_cnt 64, trig_pos 53; idx 0 -> 0x1B, idx 63 -> 0x5A.
- Immediate: mask 0x00, post 0 -> DONE after one sample; valid_cnt 1, trig_pos 0, idx 0 -> 0x00; idx 1 -> 0x00 with rd_valid_o = 1.
- Abort: abort in POST -> IDLE next cycle, busy/done/triggered 0; arm and abort in the same cycle from IDLE -> stays IDLE; rd_en in IDLE -> rd_valid pulse with data 0.
- Reset mid-POST: assert sys_rst -> all outputs 0 immediately; re-arm captures correctly. Re-arm from DONE clears valid_cnt to 0 and done_o to 0.
- LA_EDGE_TRIG_EN: data held at 0x20 through arm, then 0x21, then 0x20; value 0x20 -> trigger on the second 0x20 only; trig_pos 2 with post 0.
